bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 16, binary input width in bits.
REQ-002 SHALL have parameter DIGITS, default 5, number of BCD output digits.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to convert bin; sampled only when busy=0.
REQ-006 SHALL have port bin  input  WIDTH  binary value to convert, captured on the accepted start.
REQ-007 SHALL have port busy  output  1  high while a conversion is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new result on bcd.
REQ-009 SHALL have port bcd  output  4*DIGITS  packed BCD result; digit 0 is bits [3:0] and is least significant; each nibble feeds one seven-segment decoder.
REQ-010 SHALL have port neg  output  1  sign of the last result (see Configuration).

Function
REQ-011 SHALL implement the states IDLE, SHIFT and DONE.
REQ-012 SHALL, in IDLE with start=1, capture bin (or its magnitude), clear the BCD scratch register and the shift counter, and enter SHIFT.
REQ-013 SHALL, in each SHIFT cycle, add 3 to every scratch digit >=5, then shift {scratch, binary} left by one bit.
REQ-014 SHALL leave SHIFT for DONE after exactly WIDTH shifts; the counter is width clog2(WIDTH+1).
REQ-015 SHALL, in DONE, load bcd and neg from the scratch register, assert done for that cycle only, and return to IDLE.
REQ-016 SHALL assert done exactly WIDTH+1 cycles after the cycle in which start was accepted (17 cycles at the defaults).
REQ-017 SHALL drive busy=1 in SHIFT and DONE, and busy=0 in IDLE.
REQ-018 SHALL ignore start while busy=1, with no queuing; start in the DONE cycle is also ignored.
REQ-019 SHALL hold bcd and neg stable between done pulses, including while a new conversion runs.
REQ-020 SHALL require DIGITS >= ceil(WIDTH*log10(2)) (+1 bit of magnitude when signed); a violation is an elaboration error, so no overflow output exists.
REQ-021 SHALL produce only digits 0-9 on every nibble of bcd.

Reset
REQ-022 SHALL, while reset=1, force state=IDLE, busy=0, done=0, bcd=0, neg=0 and clear scratch and counter.
REQ-023 SHALL, when reset is asserted mid-conversion, abort the conversion with no done pulse; reset takes priority over a simultaneous start.
REQ-024 SHALL accept start in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL use the macro BIN2BCD_SIGNED_EN.
REQ-026 SHALL, with BIN2BCD_SIGNED_EN defined, treat bin as two's complement: convert |bin|, and set neg=bin[WIDTH-1] at DONE; the most negative value converts correctly (-32768 gives 32768).
REQ-027 SHALL, without BIN2BCD_SIGNED_EN, treat bin as unsigned, tie neg to 0, and compile out all sign logic.

Structure
REQ-028 SHALL place the state enum type, the digit-width constant (4) and the add-3 threshold constant (5) in the shared package bcd_pkg.
REQ-029 SHALL implement per-digit correction in the combinational sub-module bcd_add3 (4-bit in, 4-bit out), instantiated DIGITS times.

Verification
REQ-030 Unsigned, bin=0, start pulse -> done 17 cycles later, bcd=0x00000, neg=0.
REQ-031 Unsigned, bin=65535 -> bcd=0x65535; bin=1234 -> bcd=0x01234; busy high for exactly 17 cycles.
REQ-032 bin=42 started, then start with bin=99 at cycle 5 -> single done, bcd=0x00042; the second start is ignored.
REQ-033 Reset asserted at cycle 8 of a conversion of 500 -> no done pulse, bcd=0, busy=0; a new start after reset gives 0x00500.
REQ-034 Signed build: bin=16'hFFFF -> bcd=0x00001, neg=1; bin=16'h8000 -> bcd=0x32768, neg=1; bin=16'h7FFF -> bcd=0x32767, neg=0.
REQ-035 Back-to-back starts issued the cycle busy falls -> consecutive done pulses 18 cycles apart, each with the correct result.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and the double-dabble add-3 threshold.
package bcd_pkg;

    localparam int         DIGIT_W     = 4;
    localparam logic [3:0] ADD3_THRESH = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble per-digit correction: any digit of 5 or more gets 3 added
// so that the following left shift carries correctly into the next digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // Add 3 to digits at or above the threshold, pass others through.
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADD3_THRESH) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle).
// Optional feature macro: BIN2BCD_SIGNED_EN -- when defined, bin is two's
// complement, |bin| is converted and neg reports the sign; otherwise bin is
// unsigned and neg is tied low.
module bin2bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [WIDTH-1:0]        bin,
    output logic                    busy,
    output logic                    done,
    output logic [4*DIGITS-1:0]     bcd,
    output logic                    neg
);

    localparam int CNT_W      = $clog2(WIDTH + 1);
    localparam int BCD_W      = DIGIT_W * DIGITS;
    // ceil(WIDTH * log10(2)) in integer arithmetic; a signed magnitude of
    // up to 2^(WIDTH-1) needs the same number of digits.
    localparam int REQ_DIGITS = (WIDTH * 30103 + 99999) / 100000;

    if (DIGITS < REQ_DIGITS) begin : g_digits_check
        $error("bin2bcd_seq: DIGITS too small for WIDTH");
    end

    state_t             r_state;
    logic [WIDTH-1:0]   r_bin;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;

    logic [WIDTH-1:0]   w_mag;
    logic [BCD_W-1:0]   w_corr;
    logic [BCD_W-1:0]   w_scratch_next;
    logic               w_last;

`ifdef BIN2BCD_SIGNED_EN
    logic               r_sign;
    logic               r_neg;

    // Two's complement magnitude; 0x8000 maps onto itself, read as 32768.
    assign w_mag = bin[WIDTH-1] ? ((~bin) + WIDTH'(1)) : bin;
    assign neg   = r_neg;

    // Capture the sign on accept and publish it together with the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign <= 1'b0;
            r_neg  <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_sign <= bin[WIDTH-1];
            r_neg  <= r_neg;
        end else if ((r_state == ST_SHIFT) && w_last) begin
            r_sign <= r_sign;
            r_neg  <= r_sign;
        end else begin
            r_sign <= r_sign;
            r_neg  <= r_neg;
        end
    end
`else
    assign w_mag = bin;
    assign neg   = 1'b0;
`endif

    // One add-3 corrector per BCD digit of the scratch register.
    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        bcd_add3 u_add3 (
            .i_digit (r_scratch[d*DIGIT_W +: DIGIT_W]),
            .o_digit (w_corr[d*DIGIT_W +: DIGIT_W])
        );
    end

    // Corrected scratch shifted left with the next binary bit entering.
    assign w_scratch_next = {w_corr[BCD_W-2:0], r_bin[WIDTH-1]};
    assign w_last         = (r_cnt == CNT_W'(WIDTH - 1));

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;

    // Conversion FSM: accept in IDLE, WIDTH shifts, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_bin     <= w_mag;
                        r_scratch <= '0;
                        r_cnt     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_SHIFT;
                    end else begin
                        r_busy    <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_scratch_next;
                    // Rotate the combined register; the bit wrapping back in
                    // is always zero because DIGITS is large enough.
                    r_bin     <= {r_bin[WIDTH-2:0], w_corr[BCD_W-1]};
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_bcd   <= w_scratch_next;
                    end else begin
                        r_state <= ST_SHIFT;
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq (default parameters). Honours the
// BIN2BCD_SIGNED_EN build macro to pick the matching vector table.
module tb_bin2bcd_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] bin;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
    logic        neg;

    int errors;
    int checks;
    int cyc;
    int done_cnt;
    int busy_cnt;
    int last_done_cyc;
    logic [19:0] last_done_bcd;
    logic        last_done_neg;

    typedef struct {
        logic [15:0] bin;
        logic [19:0] exp_bcd;
        logic        exp_neg;
    } vec_t;

    vec_t vecs[8];

    bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .bcd   (bcd),
        .neg   (neg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Record every done pulse and every busy cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            last_done_cyc = cyc;
            last_done_bcd = bcd;
            last_done_neg = neg;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One full conversion; checks latency, busy length, result and hold.
    task automatic conv(input string nm, input logic [15:0] b,
                        input logic [19:0] eb, input logic en, input bit hold_chk);
        int cs, d0, b0, k;
        cs = cyc; d0 = done_cnt; b0 = busy_cnt;
        bin = b; start = 1'b1;
        step();
        start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 40) begin step(); k++; end
        chk({nm, "_done_seen"}, done_cnt - d0, 1);
        k = 0;
        while (busy !== 1'b0 && k < 5) begin step(); k++; end
        chk({nm, "_latency"}, last_done_cyc - cs, 17);
        chk({nm, "_busy_len"}, busy_cnt - b0, 17);
        chk({nm, "_bcd"}, last_done_bcd, eb);
        chk({nm, "_neg"}, last_done_neg, en);
        if (hold_chk) begin
            repeat (3) step();
            chk({nm, "_hold"}, {neg, bcd}, {en, eb});
            chk({nm, "_pulses"}, done_cnt - d0, 1);
        end
    endtask

    initial begin
        int d0, cs, k, t1, t2;
        errors = 0; checks = 0; cyc = 0; done_cnt = 0; busy_cnt = 0;
        last_done_cyc = 0; last_done_bcd = '0; last_done_neg = 1'b0;

`ifdef BIN2BCD_SIGNED_EN
        vecs[0] = '{16'h0000, 20'h00000, 1'b0};
        vecs[1] = '{16'hFFFF, 20'h00001, 1'b1};
        vecs[2] = '{16'h8000, 20'h32768, 1'b1};
        vecs[3] = '{16'h7FFF, 20'h32767, 1'b0};
        vecs[4] = '{16'd1234, 20'h01234, 1'b0};
        vecs[5] = '{16'hFB2E, 20'h01234, 1'b1};
        vecs[6] = '{16'd10000, 20'h10000, 1'b0};
        vecs[7] = '{16'd9,    20'h00009, 1'b0};
`else
        vecs[0] = '{16'd0,     20'h00000, 1'b0};
        vecs[1] = '{16'd65535, 20'h65535, 1'b0};
        vecs[2] = '{16'd1234,  20'h01234, 1'b0};
        vecs[3] = '{16'd42,    20'h00042, 1'b0};
        vecs[4] = '{16'd9999,  20'h09999, 1'b0};
        vecs[5] = '{16'd10000, 20'h10000, 1'b0};
        vecs[6] = '{16'd32768, 20'h32768, 1'b0};
        vecs[7] = '{16'd1,     20'h00001, 1'b0};
`endif

        reset = 1'b1; start = 1'b0; bin = '0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_neg", neg, 0);
        reset = 1'b0;

        // Table-driven conversions, first one right after reset release.
        for (int i = 0; i < 8; i++) begin
            conv($sformatf("vec%0d", i), vecs[i].bin, vecs[i].exp_bcd, vecs[i].exp_neg, 1'b1);
        end

        // Start while busy is ignored.
        d0 = done_cnt; cs = cyc;
        bin = 16'd42; start = 1'b1; step(); start = 1'b0;
        repeat (4) step();
        bin = 16'd99; start = 1'b1; step(); start = 1'b0; bin = '0;
        repeat (30) step();
        chk("ign_pulses", done_cnt - d0, 1);
        chk("ign_bcd", bcd, 20'h00042);
        chk("ign_latency", last_done_cyc - cs, 17);
        chk("ign_busy", busy, 0);

        // Start in the DONE cycle is ignored.
        d0 = done_cnt;
        bin = 16'd7; start = 1'b1; step(); start = 1'b0;
        k = 0;
        while (done_cnt == d0 && k < 40) begin step(); k++; end
        bin = 16'd8; start = 1'b1; step(); start = 1'b0;
        chk("doneign_busy", busy, 0);
        repeat (20) step();
        chk("doneign_pulses", done_cnt - d0, 1);
        chk("doneign_bcd", bcd, 20'h00007);

        // Reset mid-conversion aborts; reset wins over a simultaneous start.
        d0 = done_cnt;
        bin = 16'd500; start = 1'b1; step(); start = 1'b0;
        repeat (7) step();
        reset = 1'b1; start = 1'b1; bin = 16'd123;
        step();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_bcd", bcd, 0);
        start = 1'b0; reset = 1'b0;
        chk("abort_pulses", done_cnt - d0, 0);
        conv("after_rst", 16'd500, 20'h00500, 1'b0, 1'b1);

        // Back-to-back starts issued as busy falls.
        conv("b2b_a", 16'd321, 20'h00321, 1'b0, 1'b0);
        t1 = last_done_cyc;
        conv("b2b_b", 16'd4321, 20'h04321, 1'b0, 1'b0);
        t2 = last_done_cyc;
        chk("b2b_spacing", t2 - t1, 18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
